// File: rtl/seq_ctrl_team1.sv
// Timing and control unit for the 16-bit accumulator datapath: sequence counter, decode, strobes.
// Optional interrupt cycle (irq/ien/intr_cycle) is built when INTERRUPT_CYCLE_EN is defined.
module seq_ctrl_team1 #(
    parameter int SC_W = 4
) (
    input  logic                  clk,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [15:0]           ir,
    input  logic                  ac_msb,
    input  logic                  ac_zero,
    input  logic                  e_val,
    input  logic                  dr_zero,
`ifdef INTERRUPT_CYCLE_EN
    input  logic                  irq,
    output logic                  ien,
    output logic                  intr_cycle,
`endif
    output logic [(2**SC_W)-1:0]  t,
    output logic [7:0]            d,
    output logic                  i_bit,
    output logic                  running,
    output logic                  halted,
    output logic [2:0]            bus_sel,
    output logic                  ld_ar,
    output logic                  inr_ar,
    output logic                  ld_ir,
    output logic                  ld_pc,
    output logic                  inr_pc,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  ld_dr,
    output logic                  inr_dr,
    output logic                  ld_ac,
    output logic                  inr_ac,
    output logic                  clr_ac,
    output logic                  ld_e,
    output logic                  cle,
    output logic                  cme,
    output logic [2:0]            alu_op
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [2:0] BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
                           BUS_AC = 3'd4, BUS_IR = 3'd5, BUS_MEM = 3'd7;
    localparam logic [2:0] ALU_AND = 3'd0, ALU_ADD = 3'd1, ALU_PASS = 3'd2,
                           ALU_COM = 3'd3, ALU_SHR = 3'd4, ALU_SHL = 3'd5;

    state_t            state_reg;
    logic [SC_W-1:0]   sc_reg;
    logic [7:0]        d_reg;
    logic              i_reg;
    logic              clr_sc;
    logic              halt_req;
    logic              intr_active;

    assign d       = d_reg;
    assign i_bit   = i_reg;
    assign running = (state_reg == RUN);
    assign halted  = (state_reg == HALT);

`ifdef INTERRUPT_CYCLE_EN
    logic intr_reg;
    logic ien_reg;

    assign intr_active = intr_reg;
    assign ien         = ien_reg;
    assign intr_cycle  = intr_reg;

    // ien is sampled before the ION/IOF update, so ION itself never triggers an interrupt
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            intr_reg <= 1'b0;
            ien_reg  <= 1'b0;
        end else if (state_reg == RUN) begin
            if (intr_reg) begin
                if (clr_sc) begin
                    intr_reg <= 1'b0;
                    ien_reg  <= 1'b0;
                end
            end else begin
                if (clr_sc && ien_reg && irq && !halt_req)
                    intr_reg <= 1'b1;
                if (t[3] && d_reg[7] && i_reg) begin
                    if (ir[7])
                        ien_reg <= 1'b1;
                    else if (ir[6])
                        ien_reg <= 1'b0;
                end
            end
        end
    end
`else
    assign intr_active = 1'b0;
`endif

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            sc_reg    <= '0;
            d_reg     <= '0;
            i_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        state_reg <= RUN;
                        sc_reg    <= '0;
                    end
                end
                RUN: begin
                    if (clr_sc) begin
                        sc_reg <= '0;
                        d_reg  <= '0;
                        i_reg  <= 1'b0;
                        if (halt_req)
                            state_reg <= HALT;
                    end else begin
                        sc_reg <= sc_reg + SC_W'(1);
                        if (t[2] && !intr_active) begin
                            d_reg <= 8'(1) << ir[14:12];
                            i_reg <= ir[15];
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        t = '0;
        if (state_reg == RUN)
            t[sc_reg] = 1'b1;
    end

    always_comb begin
        bus_sel  = BUS_NONE;
        alu_op   = ALU_AND;
        ld_ar    = 1'b0;
        inr_ar   = 1'b0;
        ld_ir    = 1'b0;
        ld_pc    = 1'b0;
        inr_pc   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ld_dr    = 1'b0;
        inr_dr   = 1'b0;
        ld_ac    = 1'b0;
        inr_ac   = 1'b0;
        clr_ac   = 1'b0;
        ld_e     = 1'b0;
        cle      = 1'b0;
        cme      = 1'b0;
        clr_sc   = 1'b0;
        halt_req = 1'b0;
        if (intr_active) begin
            // interrupt cycle: save PC at address 0, jump to 1 (AR/PC cleared via empty bus)
            if (t[0]) begin
                ld_ar = 1'b1;
            end else if (t[1]) begin
                bus_sel = BUS_PC;
                mem_wr  = 1'b1;
            end else if (t[2]) begin
                ld_pc = 1'b1;
            end else begin
                inr_pc = t[3];
                clr_sc = 1'b1;
            end
        end else if (t[0]) begin
            bus_sel = BUS_PC;
            ld_ar   = 1'b1;
        end else if (t[1]) begin
            bus_sel = BUS_MEM;
            mem_rd  = 1'b1;
            ld_ir   = 1'b1;
            inr_pc  = 1'b1;
        end else if (t[2]) begin
            bus_sel = BUS_IR;
            ld_ar   = 1'b1;
        end else if (t[3]) begin
            if (d_reg[7] && !i_reg) begin
                clr_ac   = ir[11];
                cle      = ir[10];
                cme      = ir[8];
                inr_ac   = ir[5];
                ld_ac    = ir[9] | ir[7] | ir[6];
                ld_e     = ir[7] | ir[6];
                alu_op   = ir[9] ? ALU_COM : (ir[7] ? ALU_SHR : (ir[6] ? ALU_SHL : ALU_AND));
                inr_pc   = (ir[4] & ~ac_msb) | (ir[3] & ac_msb) | (ir[2] & ac_zero) | (ir[1] & ~e_val);
                halt_req = ir[0];
                clr_sc   = 1'b1;
            end else if (d_reg[7]) begin
                clr_sc = 1'b1;
            end else if (i_reg) begin
                bus_sel = BUS_MEM;
                mem_rd  = 1'b1;
                ld_ar   = 1'b1;
            end
        end else if (t[4]) begin
            if (d_reg[0] | d_reg[1] | d_reg[2] | d_reg[6]) begin
                bus_sel = BUS_MEM;
                mem_rd  = 1'b1;
                ld_dr   = 1'b1;
            end else if (d_reg[3]) begin
                bus_sel = BUS_AC;
                mem_wr  = 1'b1;
                clr_sc  = 1'b1;
            end else if (d_reg[4]) begin
                bus_sel = BUS_AR;
                ld_pc   = 1'b1;
                clr_sc  = 1'b1;
            end else if (d_reg[5]) begin
                bus_sel = BUS_PC;
                mem_wr  = 1'b1;
                inr_ar  = 1'b1;
            end
        end else if (t[5]) begin
            if (d_reg[0] | d_reg[1] | d_reg[2]) begin
                ld_ac  = 1'b1;
                ld_e   = d_reg[1];
                alu_op = d_reg[1] ? ALU_ADD : (d_reg[2] ? ALU_PASS : ALU_AND);
                clr_sc = 1'b1;
            end else if (d_reg[5]) begin
                bus_sel = BUS_AR;
                ld_pc   = 1'b1;
                clr_sc  = 1'b1;
            end else if (d_reg[6]) begin
                inr_dr = 1'b1;
            end
        end else if (t[6] && d_reg[6]) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            inr_pc  = dr_zero;
            clr_sc  = 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_ctrl_team1.sv
// Scoreboard bench for seq_ctrl_team1: per-instruction cycle tables from the instruction set, checked every cycle.
module tb_seq_ctrl_team1;

    logic        clk = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ir = '0;
    logic        ac_msb = 1'b0, ac_zero = 1'b0, e_val = 1'b0, dr_zero = 1'b0;
    logic [15:0] t;
    logic [7:0]  d;
    logic        i_bit, running, halted;
    logic [2:0]  bus_sel, alu_op;
    logic        ld_ar, inr_ar, ld_ir, ld_pc, inr_pc, mem_rd, mem_wr, ld_dr, inr_dr;
    logic        ld_ac, inr_ac, clr_ac, ld_e, cle, cme;
`ifdef INTERRUPT_CYCLE_EN
    logic        irq = 1'b0;
    logic        ien, intr_cycle;
    logic        p_irq = 1'b0;
    logic        m_ien = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_ctrl_team1 #(.SC_W(4)) dut (
        .clk(clk), .RST_N(RST_N), .start(start), .ir(ir),
        .ac_msb(ac_msb), .ac_zero(ac_zero), .e_val(e_val), .dr_zero(dr_zero),
`ifdef INTERRUPT_CYCLE_EN
        .irq(irq), .ien(ien), .intr_cycle(intr_cycle),
`endif
        .t(t), .d(d), .i_bit(i_bit), .running(running), .halted(halted), .bus_sel(bus_sel),
        .ld_ar(ld_ar), .inr_ar(inr_ar), .ld_ir(ld_ir), .ld_pc(ld_pc), .inr_pc(inr_pc),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ld_dr(ld_dr), .inr_dr(inr_dr), .ld_ac(ld_ac),
        .inr_ac(inr_ac), .clr_ac(clr_ac), .ld_e(ld_e), .cle(cle), .cme(cme), .alu_op(alu_op)
    );

    typedef struct packed {
        logic [15:0] t;
        logic [7:0]  d;
        logic        i_bit;
        logic        running;
        logic        halted;
        logic [2:0]  bus_sel;
        logic [14:0] strb;
        logic [2:0]  alu_op;
`ifdef INTERRUPT_CYCLE_EN
        logic        ien;
        logic        intr;
`endif
    } obs_t;

    localparam int S_LD_AR = 14, S_INR_AR = 13, S_LD_IR = 12, S_LD_PC = 11, S_INR_PC = 10,
                   S_MEM_RD = 9, S_MEM_WR = 8, S_LD_DR = 7, S_INR_DR = 6, S_LD_AC = 5,
                   S_INR_AC = 4, S_CLR_AC = 3, S_LD_E = 2, S_CLE = 1, S_CME = 0;

    obs_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] p_ir = '0;
    logic [3:0]  p_fl = '0;

    function automatic obs_t idle_obs(input logic h);
        obs_t o = '0;
        o.halted = h;
`ifdef INTERRUPT_CYCLE_EN
        o.ien = m_ien;
`endif
        return o;
    endfunction

    function automatic obs_t run_obs(input int k, input logic [7:0] dv, input logic iv);
        obs_t o = '0;
        o.running = 1'b1;
        o.t       = 16'(1) << k;
        o.d       = dv;
        o.i_bit   = iv;
`ifdef INTERRUPT_CYCLE_EN
        o.ien = m_ien;
`endif
        return o;
    endfunction

    // one clock: apply inputs just after the edge, queue what the outputs must show this cycle
    task automatic cyc(input logic st, input logic rn, input obs_t e);
        @(posedge clk);
        #1;
        start = st;
        RST_N = rn;
        ir    = p_ir;
        {ac_msb, ac_zero, e_val, dr_zero} = p_fl;
`ifdef INTERRUPT_CYCLE_EN
        irq = p_irq;
`endif
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = '0;
            a.t = t; a.d = d; a.i_bit = i_bit; a.running = running; a.halted = halted;
            a.bus_sel = bus_sel; a.alu_op = alu_op;
            a.strb = {ld_ar, inr_ar, ld_ir, ld_pc, inr_pc, mem_rd, mem_wr, ld_dr, inr_dr,
                      ld_ac, inr_ac, clr_ac, ld_e, cle, cme};
`ifdef INTERRUPT_CYCLE_EN
            a.ien = ien; a.intr = intr_cycle;
`endif
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_obs @%0t ir=%h: actual t=%h d=%h i=%b run=%b halt=%b bus=%0d strb=%b alu=%0d (%h), required t=%h d=%h i=%b run=%b halt=%b bus=%0d strb=%b alu=%0d (%h)",
                         $time, ir, a.t, a.d, a.i_bit, a.running, a.halted, a.bus_sel, a.strb, a.alu_op, a,
                         e.t, e.d, e.i_bit, e.running, e.halted, e.bus_sel, e.strb, e.alu_op, e);
            end
        end
    end

    // Instruction-level reference: the cycles an instruction takes and what each cycle must assert.
    // abort_at >= 3 pulls RST_N low in that execute step instead of finishing the instruction.
    task automatic run_instr(input logic [15:0] instr, input logic [3:0] fl, input logic irq_v, input int abort_at);
        obs_t       ex[$];
        obs_t       e;
        logic [7:0] dv;
        logic       iv;
        logic       halt;
        logic [2:0] op;
        p_ir = instr;
        p_fl = fl;
`ifdef INTERRUPT_CYCLE_EN
        p_irq = irq_v;
`endif
        op   = instr[14:12];
        dv   = 8'h01 << op;
        iv   = instr[15];
        halt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e = run_obs(k, 8'h00, 1'b0);
            if (k == 0) begin e.bus_sel = 3'd2; e.strb[S_LD_AR] = 1'b1; end
            if (k == 1) begin
                e.bus_sel = 3'd7; e.strb[S_MEM_RD] = 1'b1; e.strb[S_LD_IR] = 1'b1; e.strb[S_INR_PC] = 1'b1;
            end
            if (k == 2) begin e.bus_sel = 3'd5; e.strb[S_LD_AR] = 1'b1; end
            cyc((k == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1, e);
        end
        e = run_obs(3, dv, iv);
        if (op == 3'd7 && !iv) begin
            e.strb[S_CLR_AC] = instr[11];
            e.strb[S_CLE]    = instr[10];
            e.strb[S_CME]    = instr[8];
            e.strb[S_INR_AC] = instr[5];
            if (instr[9])      begin e.strb[S_LD_AC] = 1'b1; e.alu_op = 3'd3; end
            else if (instr[7]) begin e.strb[S_LD_AC] = 1'b1; e.alu_op = 3'd4; end
            else if (instr[6]) begin e.strb[S_LD_AC] = 1'b1; e.alu_op = 3'd5; end
            if (instr[7] || instr[6]) e.strb[S_LD_E] = 1'b1;
            e.strb[S_INR_PC] = (instr[4] && !fl[3]) || (instr[3] && fl[3]) ||
                               (instr[2] && fl[2]) || (instr[1] && !fl[1]);
            halt = instr[0];
            ex.push_back(e);
        end else if (op == 3'd7) begin
            ex.push_back(e);
        end else begin
            if (iv) begin e.bus_sel = 3'd7; e.strb[S_MEM_RD] = 1'b1; e.strb[S_LD_AR] = 1'b1; end
            ex.push_back(e);
            e = run_obs(4, dv, iv);
            case (op)
                3'd0, 3'd1, 3'd2, 3'd6: begin
                    e.bus_sel = 3'd7; e.strb[S_MEM_RD] = 1'b1; e.strb[S_LD_DR] = 1'b1;
                end
                3'd3: begin e.bus_sel = 3'd4; e.strb[S_MEM_WR] = 1'b1; end
                3'd4: begin e.bus_sel = 3'd1; e.strb[S_LD_PC] = 1'b1; end
                default: begin e.bus_sel = 3'd2; e.strb[S_MEM_WR] = 1'b1; e.strb[S_INR_AR] = 1'b1; end
            endcase
            ex.push_back(e);
            if (op <= 3'd2) begin
                e = run_obs(5, dv, iv);
                e.strb[S_LD_AC] = 1'b1;
                e.alu_op = op;
                e.strb[S_LD_E] = (op == 3'd1);
                ex.push_back(e);
            end else if (op == 3'd5) begin
                e = run_obs(5, dv, iv);
                e.bus_sel = 3'd1; e.strb[S_LD_PC] = 1'b1;
                ex.push_back(e);
            end else if (op == 3'd6) begin
                e = run_obs(5, dv, iv);
                e.strb[S_INR_DR] = 1'b1;
                ex.push_back(e);
                e = run_obs(6, dv, iv);
                e.bus_sel = 3'd3; e.strb[S_MEM_WR] = 1'b1; e.strb[S_INR_PC] = fl[0];
                ex.push_back(e);
            end
        end
        foreach (ex[n]) begin
            if (abort_at == n + 3) begin
`ifdef INTERRUPT_CYCLE_EN
                m_ien = 1'b0;
`endif
                cyc(1'b0, 1'b0, idle_obs(1'b0));
                $display("instr ir=%h aborted by reset at T%0d", instr, abort_at);
                return;
            end
            cyc(1'b0, 1'b1, ex[n]);
        end
        if (halt) begin
            repeat (3) cyc(1'b0, 1'b1, idle_obs(1'b1));
            cyc(1'b1, 1'b1, idle_obs(1'b1));
        end else begin
`ifdef INTERRUPT_CYCLE_EN
            logic take;
            take = m_ien && irq_v;
            if (op == 3'd7 && iv) begin
                if (instr[7]) m_ien = 1'b1;
                else if (instr[6]) m_ien = 1'b0;
            end
            if (take) begin
                for (int k = 0; k < 4; k++) begin
                    e = run_obs(k, 8'h00, 1'b0);
                    e.intr = 1'b1;
                    e.ien  = 1'b1;
                    if (k == 0) e.strb[S_LD_AR] = 1'b1;
                    if (k == 1) begin e.bus_sel = 3'd2; e.strb[S_MEM_WR] = 1'b1; end
                    if (k == 2) e.strb[S_LD_PC] = 1'b1;
                    if (k == 3) e.strb[S_INR_PC] = 1'b1;
                    cyc(1'b0, 1'b1, e);
                end
                m_ien = 1'b0;
            end
`endif
        end
        $display("instr ir=%h flags=%b irq=%b cycles=%0d halt=%b", instr, fl, irq_v, ex.size() + 3, halt);
    endtask

    initial begin
        logic [15:0] instr;
        repeat (2) cyc(1'b0, 1'b0, idle_obs(1'b0));
        repeat (2) cyc(1'b0, 1'b1, idle_obs(1'b0));
        cyc(1'b1, 1'b1, idle_obs(1'b0));
        run_instr(16'h7020, 4'b0000, 1'b0, -1);
        run_instr(16'h7001, 4'b0000, 1'b0, -1);
        run_instr(16'h9005, 4'b0000, 1'b0, -1);
        run_instr(16'h6010, 4'b0001, 1'b0, -1);
        run_instr(16'h6010, 4'b0000, 1'b0, -1);
        run_instr(16'h701E, 4'b1010, 1'b0, -1);
        run_instr(16'h7380, 4'b0100, 1'b0, -1);
        run_instr(16'h5123, 4'b0000, 1'b0, -1);
`ifdef INTERRUPT_CYCLE_EN
        run_instr(16'hF080, 4'b0000, 1'b1, -1);
        run_instr(16'h2003, 4'b0000, 1'b1, -1);
        run_instr(16'h3004, 4'b0000, 1'b1, -1);
`endif
        for (int n = 0; n < 120; n++) begin
            instr = 16'($urandom);
            if (instr[14:12] == 3'd7 && !instr[15] && instr[0] && $urandom_range(0, 5) != 0)
                instr[0] = 1'b0;
            run_instr(instr, 4'($urandom), ($urandom_range(0, 3) == 0), -1);
        end
        run_instr(16'h6010, 4'b0001, 1'b0, 4);
        repeat (3) cyc(1'b0, 1'b1, idle_obs(1'b0));
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_ctrl_team1.md
Name: seq_ctrl_team1

Overview:
- Timing and control unit for the 16-bit accumulator datapath (AR, PC, DR, IR, AC, E, memory, common bus).
- Contains a 4-bit sequence counter, decodes the instruction, and issues every register strobe, bus select and ALU op.
- Sequences fetch → decode → indirect → execute and stops on HLT.

Parameters:
SC_W, 4, sequence-counter width; t is 2**SC_W bits (16 at default)

Ports:
clk  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  leave IDLE/HALT and begin fetch
ir  in  16  IR contents; valid from T2
ac_msb  in  1  AC[15]
ac_zero  in  1  AC==0
e_val  in  1  E flag
dr_zero  in  1  DR==0 (ISZ)
t  out  16  one-hot timing T0..T15
d  out  8  one-hot opcode decode of IR[14:12]
i_bit  out  1  IR[15]
running  out  1  RUN state
halted  out  1  HALT state
bus_sel  out  3  0 none(bus=0), 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM
ld_ar, inr_ar, ld_ir, ld_pc, inr_pc, mem_rd, mem_wr, ld_dr, inr_dr, ld_ac, inr_ac, clr_ac, ld_e, cle, cme  out  1 each  datapath strobes
alu_op  out  3  0 AND, 1 ADD, 2 PASS-DR, 3 COM, 4 SHR, 5 SHL

Behaviour:
- States: IDLE, RUN, HALT.
- RST_N low (any time, including mid-instruction): IDLE, SC=0, d=0, i_bit=0, all strobes/bus_sel/alu_op 0, t=0, running=0, halted=0.
- start in IDLE or HALT: next cycle RUN with SC=0. start in RUN is ignored.
- t: one-hot of SC in RUN, 0 otherwise. Strobes are combinational from state, t, d, i_bit and ir; outputs are registered only through SC, d and i_bit.
- SC increments each RUN cycle. clr_sc (internal) sets SC=0 next cycle. SC wrap past 15 is unreachable; if it occurs, SC returns to 0.
- T0: bus_sel=PC, ld_ar.
- T1: mem_rd, bus_sel=MEM, ld_ir, inr_pc.
- T2: d and i_bit registered from ir, held until clr_sc; bus_sel=IR, ld_ar.
- T3, by case:
  - d7 & ~i (register reference): execute per B=ir[11:0], then clr_sc.
  - d7 & i (I/O): NOP, clr_sc.
  - ~d7 & i (indirect): mem_rd, bus_sel=MEM, ld_ar.
  - ~d7 & ~i: idle.
- Register reference at T3 (several bits may be set at once; all listed strobes assert together):
  - B11 clr_ac; B10 cle; B8 cme; B5 inr_ac.
  - B9 COM, B7 SHR (CIR, with ld_e), B6 SHL (CIL, with ld_e) each assert ld_ac with alu_op priority COM > SHR > SHL.
  - Skips assert a single inr_pc pulse, OR of: B4 & ~ac_msb, B3 & ac_msb, B2 & ac_zero, B1 & ~e_val.
  - B0: after T3, go to HALT.
- Memory reference:
  - d0/d1/d2 (AND/ADD/LDA): T4 mem_rd, bus=MEM, ld_dr; T5 ld_ac, alu_op 0/1/2 respectively, ld_e on ADD only, clr_sc.
  - d3 (STA): T4 bus=AC, mem_wr, clr_sc.
  - d4 (BUN): T4 bus=AR, ld_pc, clr_sc.
  - d5 (BSA): T4 bus=PC, mem_wr, inr_ar; T5 bus=AR, ld_pc, clr_sc.
  - d6 (ISZ): T4 mem_rd, ld_dr; T5 inr_dr; T6 bus=DR, mem_wr, inr_pc if dr_zero, clr_sc.
- HALT: t=0, halted=1, no strobes until start.

Optional Feature:
INTERRUPT_CYCLE_EN
- Enabled:
  - Adds input irq, and outputs ien and intr_cycle.
  - ien resets to 0. I/O at T3: B7 (ION) sets ien, B6 (IOF) clears it.
  - At any clr_sc with ien & irq, the next four cycles form the interrupt cycle (intr_cycle=1, t follows SC):
    - RT0: bus=none, ld_ar.
    - RT1: bus=PC, mem_wr.
    - RT2: bus=none, ld_pc.
    - RT3: inr_pc, ien←0, clr_sc.
  - HLT takes priority over a pending interrupt.
- Disabled: ports absent; all I/O instructions are NOPs.

Test Plan:
- Reset: assert RST_N low during T4 of ISZ → same cycle t=0 and all strobes 0; release, no start → stays IDLE, t=0.
- ir=16'h7020 (INC) after start: T0 ld_ar/bus 2; T1 ld_ir, mem_rd, inr_pc; T3 d=8'h80, i_bit=0, inr_ac; next cycle t=16'h0001.
- ir=16'h7001 (HLT): halted=1, t=0 from cycle after T3; pulse start → t=16'h0001, running=1.
- ir=16'h9005 (indirect ADD): T3 mem_rd, ld_ar, bus 7; T4 ld_dr; T5 ld_ac, alu_op=1, ld_e; then T0.
- ir=16'h6010 (ISZ): with dr_zero=1 → T6 mem_wr, inr_pc, bus 3; repeat with dr_zero=0 → no inr_pc.
- INTERRUPT_CYCLE_EN: ir=16'hF080 (ION), then irq=1 during next instruction → intr_cycle high 4 cycles after its clr_sc, RT1 mem_wr bus 2, ien=0 after RT3.
